param_stack: RTL

Parametrised LIFO stack with registered push, pop and indexed peek, sized by data width and depth, with full/empty/count status and error signalling. It is the next-generation stack primitive for the datapath and replaces fixed 4-bit × 5 storage behind a tri-state bus. Separate input and output buses let it sit directly between a command sequencer and downstream logic without bus turnaround.

---
 rtl/param_stack.sv | 121 ++++++++++++
 1 files changed

// File: rtl/param_stack.sv
// Parametrised LIFO stack over a circular buffer with registered push/pop/peek and status flags.
// Define STACK_WRAP_EN to make a push into a full stack overwrite the oldest entry instead of being rejected.
module param_stack #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 5,
   parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       cmd,
   input  logic [IW-1:0]    index,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             error
);

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_PUSH = 2'b01,
      CMD_POP  = 2'b10,
      CMD_PEEK = 2'b11
   } cmd_t;

   localparam logic [IW-1:0] LAST     = IW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [IW:0]   DEPTH_W  = (IW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    top;
   logic [IW-1:0]    top_inc;
   logic [IW-1:0]    top_dec;
   logic [IW-1:0]    peek_addr;
   logic [IW:0]      top_w;
   logic [IW:0]      index_w;
   logic [CW-1:0]    count_next;
   cmd_t             op;
   logic             do_push;
   logic             do_pop;
   logic             do_peek;
   logic             reject;

   // Pointer arithmetic wraps by explicit compare so DEPTH need not be a power of two.
   always_comb begin
      top_w     = {1'b0, top};
      index_w   = {1'b0, index};
      top_inc   = (top == LAST) ? '0 : top + IW'(1);
      top_dec   = (top == '0) ? LAST : top - IW'(1);
      peek_addr = (top_w >= index_w) ? IW'(top_w - index_w)
                                     : IW'(top_w + DEPTH_W - index_w);
   end

   always_comb begin
      op         = cmd_t'(cmd);
      do_push    = 1'b0;
      do_pop     = 1'b0;
      do_peek    = 1'b0;
      reject     = 1'b0;
      count_next = count;
      case (op)
         CMD_PUSH: begin
            if (!full) begin
               do_push    = 1'b1;
               count_next = count + CW'(1);
            end else begin
`ifdef STACK_WRAP_EN
               do_push    = 1'b1;
`else
               reject     = 1'b1;
`endif
            end
         end
         CMD_POP: begin
            if (!empty) begin
               do_pop     = 1'b1;
               count_next = count - CW'(1);
            end else begin
               reject     = 1'b1;
            end
         end
         CMD_PEEK: begin
            if (CW'(index) < count) do_peek = 1'b1;
            else                    reject  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         top       <= LAST;
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         data_out  <= '0;
         out_valid <= 1'b0;
         error     <= 1'b0;
      end else begin
         out_valid <= do_pop | do_peek;
         error     <= reject;
         count     <= count_next;
         full      <= (count_next == FULL_CNT);
         empty     <= (count_next == '0);
         if (do_push) begin
            mem[top_inc] <= data_in;
            top          <= top_inc;
         end
         if (do_pop) begin
            data_out <= mem[top];
            top      <= top_dec;
         end
         if (do_peek) data_out <= mem[peek_addr];
      end
   end

endmodule
